// File: rtl/vga_pkg.sv
// vga_pkg
// Shared constants for the 640x480@60 Hz raster: porch and pulse lengths,
// derived line/frame totals, sync start/end positions, the layout of the
// 12-bit colour word and the sync polarity.
// No ports (package).
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive counter ranges during which the sync pulses are asserted.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Counters and coordinates are 10 bits wide (800 and 525 both fit).
    localparam int CNT_W = 10;

    // Colour word layout: [11:8]=B, [7:4]=G, [3:0]=R.
    localparam int COLOR_W     = 4;
    localparam int COLOR_R_LSB = 0;
    localparam int COLOR_G_LSB = 4;
    localparam int COLOR_B_LSB = 8;

    // Both syncs are active-low for this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/vga_scan_counter.sv
// vga_scan_counter
// Stage-0 raster scanner: free-running horizontal/vertical counters plus the
// combinational display-enable, sync and frame-start flags they imply.
// Ports:
//   vga_clk  in   pixel clock
//   vga_rst  in   synchronous active-low reset
//   h_cnt    out  column counter, 0..line total-1
//   v_cnt    out  row counter, 0..frame total-1
//   de0      out  counters address a visible pixel
//   hs0/vs0  out  undelayed syncs (SYNC_ACTIVE polarity)
//   fs0      out  counters sit at (0,0)
module vga_scan_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE_CFG = H_ACTIVE,
    parameter int H_FP_CFG     = H_FP,
    parameter int H_SYNC_CFG   = H_SYNC,
    parameter int H_BP_CFG     = H_BP,
    parameter int V_ACTIVE_CFG = V_ACTIVE,
    parameter int V_FP_CFG     = V_FP,
    parameter int V_SYNC_CFG   = V_SYNC,
    parameter int V_BP_CFG     = V_BP
) (
    input  logic             vga_clk,
    input  logic             vga_rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             de0,
    output logic             hs0,
    output logic             vs0,
    output logic             fs0
);

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE_CFG);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG + H_BP_CFG - 1);
    localparam logic [CNT_W-1:0] H_SS      = CNT_W'(H_ACTIVE_CFG + H_FP_CFG);
    localparam logic [CNT_W-1:0] H_SE      = CNT_W'(H_ACTIVE_CFG + H_FP_CFG + H_SYNC_CFG - 1);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE_CFG);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG + V_BP_CFG - 1);
    localparam logic [CNT_W-1:0] V_SS      = CNT_W'(V_ACTIVE_CFG + V_FP_CFG);
    localparam logic [CNT_W-1:0] V_SE      = CNT_W'(V_ACTIVE_CFG + V_FP_CFG + V_SYNC_CFG - 1);

    // The row counter only moves when the column counter wraps, so a frame
    // wrap happens on the same edge as the last line's column wrap.
    always_ff @(posedge vga_clk) begin
        if (!vga_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // vs0 depends only on v_cnt, so it covers whole lines and switches at h_cnt=0.
    assign de0 = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs0 = ((h_cnt >= H_SS) && (h_cnt <= H_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs0 = ((v_cnt >= V_SS) && (v_cnt <= V_SE)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign fs0 = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// VGA raster controller. Presents pixel coordinates to a registered pixel
// source and delays the syncs by the same two clocks the colour takes, so
// colour and sync leave on the same edge.
// Ports:
//   vga_clk      in   25 MHz pixel clock
//   vga_rst      in   synchronous active-low reset
//   pixel_data   in   12-bit {B,G,R} colour, one clock after x_pos/y_pos
//   x_pos/y_pos  out  visible coordinate being requested, 0 in blanking
//   pixel_req    out  x_pos/y_pos address a visible pixel
//   vga_hs/vs    out  active-low syncs to the connector
//   vga_r/g/b    out  4-bit colour to the DAC, 0 in blanking
//   frame_start  out  one-clock pulse with pixel (0,0) at the pins
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE_CFG = H_ACTIVE,
    parameter int H_FP_CFG     = H_FP,
    parameter int H_SYNC_CFG   = H_SYNC,
    parameter int H_BP_CFG     = H_BP,
    parameter int V_ACTIVE_CFG = V_ACTIVE,
    parameter int V_FP_CFG     = V_FP,
    parameter int V_SYNC_CFG   = V_SYNC,
    parameter int V_BP_CFG     = V_BP
) (
    input  logic             vga_clk,
    input  logic             vga_rst,
    input  logic [11:0]      pixel_data,
    output logic [CNT_W-1:0] x_pos,
    output logic [CNT_W-1:0] y_pos,
    output logic             pixel_req,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             de0, hs0, vs0, fs0;
    logic             de1, hs1, vs1, fs1;

    vga_scan_counter #(
        .H_ACTIVE_CFG (H_ACTIVE_CFG),
        .H_FP_CFG     (H_FP_CFG),
        .H_SYNC_CFG   (H_SYNC_CFG),
        .H_BP_CFG     (H_BP_CFG),
        .V_ACTIVE_CFG (V_ACTIVE_CFG),
        .V_FP_CFG     (V_FP_CFG),
        .V_SYNC_CFG   (V_SYNC_CFG),
        .V_BP_CFG     (V_BP_CFG)
    ) u_scan (
        .vga_clk (vga_clk),
        .vga_rst (vga_rst),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .de0     (de0),
        .hs0     (hs0),
        .vs0     (vs0),
        .fs0     (fs0)
    );

    // Gating with vga_rst keeps the address bus quiet for the whole reset,
    // including the cycle before the counters are first cleared.
    assign pixel_req = de0 & vga_rst;
    assign x_pos     = pixel_req ? h_cnt : '0;
    assign y_pos     = pixel_req ? v_cnt : '0;

    // Stage 1: hold the flags while the pixel source fetches the colour.
    always_ff @(posedge vga_clk) begin
        if (!vga_rst) begin
            de1 <= 1'b0;
            hs1 <= ~SYNC_ACTIVE;
            vs1 <= ~SYNC_ACTIVE;
            fs1 <= 1'b0;
        end else begin
            de1 <= de0;
            hs1 <= hs0;
            vs1 <= vs0;
            fs1 <= fs0;
        end
    end

    // Stage 2: pin registers. pixel_data now belongs to the stage-1 address,
    // so de1 decides whether it is shown or blanked.
    always_ff @(posedge vga_clk) begin
        if (!vga_rst) begin
            vga_hs      <= ~SYNC_ACTIVE;
            vga_vs      <= ~SYNC_ACTIVE;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hs      <= hs1;
            vga_vs      <= vs1;
            frame_start <= fs1;
            vga_r       <= de1 ? pixel_data[COLOR_R_LSB +: COLOR_W] : '0;
            vga_g       <= de1 ? pixel_data[COLOR_G_LSB +: COLOR_W] : '0;
            vga_b       <= de1 ? pixel_data[COLOR_B_LSB +: COLOR_W] : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl
// Self-checking bench for vga_timing_ctrl. Horizontal timing is the real
// 640/800 line; the frame is shortened to 13 lines (6 visible, 2 front
// porch, 2 sync, 3 back porch) so whole frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int TB_VA    = 6;
    localparam int TB_VFP   = 2;
    localparam int TB_VSYNC = 2;
    localparam int TB_VBP   = 3;
    localparam int TB_VT    = TB_VA + TB_VFP + TB_VSYNC + TB_VBP;
    localparam int TB_VS0   = TB_VA + TB_VFP;
    localparam int FRAME    = 800 * TB_VT;

    logic        vga_clk;
    logic        vga_rst;
    logic [11:0] pixel_data;
    logic [9:0]  x_pos, y_pos;
    logic        pixel_req, vga_hs, vga_vs, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;

    int          checks, passes, cyc, mode;
    logic [9:0]  prev_x, prev_y;
    logic [11:0] lut [256];

    typedef struct packed {
        logic        req;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    vga_timing_ctrl #(
        .V_ACTIVE_CFG (TB_VA),
        .V_FP_CFG     (TB_VFP),
        .V_SYNC_CFG   (TB_VSYNC),
        .V_BP_CFG     (TB_VBP)
    ) dut (
        .vga_clk     (vga_clk),
        .vga_rst     (vga_rst),
        .pixel_data  (pixel_data),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pixel_req   (pixel_req),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // Colour the modelled pixel source returns for a coordinate.
    function automatic logic [11:0] src_word(int m, logic [9:0] x, logic [9:0] y);
        logic [7:0] idx;
        idx = {y[3:0], x[3:0]};
        case (m)
            0:       return {4'h0, y[3:0], x[3:0]};
            1:       return 12'hfff;
            default: return lut[idx];
        endcase
    endfunction

    // Expected outputs c clocks after reset release: addresses come from the
    // raster position c, pins from position c-2.
    function automatic exp_t model(int c);
        exp_t e;
        int h, v, ph, pv;
        h = c % 800;
        v = (c / 800) % TB_VT;
        e.req = (h < 640) && (v < TB_VA);
        e.x   = e.req ? 10'(h) : 10'd0;
        e.y   = e.req ? 10'(v) : 10'd0;
        if (c < 2) begin
            e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.rgb = 12'h000;
        end else begin
            ph = (c - 2) % 800;
            pv = ((c - 2) / 800) % TB_VT;
            e.hs  = !(ph >= 656 && ph <= 751);
            e.vs  = !(pv >= TB_VS0 && pv < TB_VS0 + TB_VSYNC);
            e.fs  = (ph == 0) && (pv == 0);
            e.rgb = (ph < 640 && pv < TB_VA) ? src_word(mode, 10'(ph), 10'(pv)) : 12'h000;
        end
        return e;
    endfunction

    // One clock; the source registers the address that was present at the edge.
    task automatic cycle();
        @(posedge vga_clk);
        cyc++;
        @(negedge vga_clk);
        pixel_data = src_word(mode, prev_x, prev_y);
        prev_x = x_pos;
        prev_y = y_pos;
    endtask

    task automatic apply_reset(int pre, int hold);
        for (int i = 0; i < pre; i++) cycle();
        vga_rst = 1'b0;
        for (int i = 0; i < hold; i++) cycle();
        vga_rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        mode = 0;
        apply_reset(0, 3);
        for (int i = 0; i < int'($urandom_range(100, 700)); i++) cycle();
        vga_rst = 1'b0;
        #1;
        checks++;
        if (pixel_req !== 1'b0) $display("[TB] FAIL reset_req_immediate: got %b expected 0", pixel_req);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if ({vga_hs, vga_vs, frame_start, pixel_req, x_pos, y_pos, vga_b, vga_g, vga_r} !== {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000})
                $display("[TB] FAIL reset_hold: got hs=%b vs=%b fs=%b req=%b x=%0d y=%0d rgb=%h expected 1 1 0 0 0 0 000",
                         vga_hs, vga_vs, frame_start, pixel_req, x_pos, y_pos, {vga_b, vga_g, vga_r});
            else passes++;
        end
        vga_rst = 1'b1;
        cyc = 0;
        #1;
        checks++;
        if ({pixel_req, x_pos, y_pos} !== {1'b1, 10'd0, 10'd0})
            $display("[TB] FAIL reset_release_addr: got req=%b x=%0d y=%0d expected 1 0 0", pixel_req, x_pos, y_pos);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (frame_start !== (cyc == 2))
                $display("[TB] FAIL reset_frame_start: cycle %0d got %b expected %b", cyc, frame_start, (cyc == 2));
            else passes++;
        end
    endtask

    task automatic test_hsync();
        int falls[$];
        int lows[$];
        int low_run;
        logic prev_hs;
        mode = 2;
        apply_reset(int'($urandom_range(1, 1500)), 3);
        prev_hs = vga_hs;
        low_run = 0;
        for (int i = 0; i < 3900; i++) begin
            cycle();
            if (!vga_hs) low_run++;
            if (prev_hs && !vga_hs) falls.push_back(cyc);
            if (!prev_hs && vga_hs) begin lows.push_back(low_run); low_run = 0; end
            prev_hs = vga_hs;
        end
        checks++;
        if (falls.size() != 5 || lows.size() != 4)
            $display("[TB] FAIL hsync_edge_count: got falls=%0d lows=%0d expected 5 4", falls.size(), lows.size());
        else passes++;
        foreach (falls[k]) begin
            checks++;
            if (falls[k] != 658 + 800 * k) $display("[TB] FAIL hsync_fall: edge %0d got %0d expected %0d", k, falls[k], 658 + 800 * k);
            else passes++;
        end
        foreach (lows[k]) begin
            checks++;
            if (lows[k] != 96) $display("[TB] FAIL hsync_low_width: pulse %0d got %0d expected 96", k, lows[k]);
            else passes++;
        end
    endtask

    task automatic test_vsync();
        int falls[$];
        int lows[$];
        int fs_at[$];
        int low_run;
        logic prev_vs;
        mode = 1;
        apply_reset(int'($urandom_range(1, 1500)), 2);
        prev_vs = vga_vs;
        low_run = 0;
        for (int i = 0; i < 2 * FRAME + 2000; i++) begin
            cycle();
            if (!vga_vs) low_run++;
            if (prev_vs && !vga_vs) falls.push_back(cyc);
            if (!prev_vs && vga_vs) begin lows.push_back(low_run); low_run = 0; end
            if (frame_start) fs_at.push_back(cyc);
            prev_vs = vga_vs;
        end
        checks++;
        if (falls.size() != 2 || lows.size() != 2 || fs_at.size() != 3)
            $display("[TB] FAIL vsync_counts: got falls=%0d lows=%0d fs=%0d expected 2 2 3", falls.size(), lows.size(), fs_at.size());
        else passes++;
        foreach (falls[k]) begin
            checks++;
            if (falls[k] != 800 * TB_VS0 + 2 + FRAME * k)
                $display("[TB] FAIL vsync_fall: edge %0d got %0d expected %0d", k, falls[k], 800 * TB_VS0 + 2 + FRAME * k);
            else passes++;
        end
        foreach (lows[k]) begin
            checks++;
            if (lows[k] != 800 * TB_VSYNC) $display("[TB] FAIL vsync_low_width: got %0d expected %0d", lows[k], 800 * TB_VSYNC);
            else passes++;
        end
        foreach (fs_at[k]) begin
            checks++;
            if (fs_at[k] != 2 + FRAME * k) $display("[TB] FAIL frame_start_pos: pulse %0d got %0d expected %0d", k, fs_at[k], 2 + FRAME * k);
            else passes++;
        end
    endtask

    task automatic test_alignment();
        int px, py;
        mode = 0;
        apply_reset(int'($urandom_range(1, 1500)), 2);
        while (cyc < 800 * TB_VA) begin
            cycle();
            px = (cyc - 2) % 800;
            py = (cyc - 2) / 800;
            if (cyc >= 2 && px < 640 && py < TB_VA && ((px == 5 && py == 3) || $urandom_range(0, 63) == 0)) begin
                checks++;
                if (vga_r !== 4'(px) || vga_g !== 4'(py) || vga_b !== 4'h0)
                    $display("[TB] FAIL align_rgb: col %0d row %0d got r=%h g=%h b=%h expected %h %h 0",
                             px, py, vga_r, vga_g, vga_b, 4'(px), 4'(py));
                else passes++;
            end
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        mode = 1;
        apply_reset(int'($urandom_range(1, 1500)), 2);
        for (int i = 0; i < FRAME + 2; i++) begin
            cycle();
            e = model(cyc);
            checks++;
            if ({vga_b, vga_g, vga_r} !== e.rgb)
                $display("[TB] FAIL blank_rgb: cycle %0d got %h expected %h", cyc, {vga_b, vga_g, vga_r}, e.rgb);
            else passes++;
            checks++;
            if ({pixel_req, x_pos, y_pos} !== {e.req, e.x, e.y})
                $display("[TB] FAIL blank_addr: cycle %0d got req=%b x=%0d y=%0d expected %b %0d %0d",
                         cyc, pixel_req, x_pos, y_pos, e.req, e.x, e.y);
            else passes++;
        end
    endtask

    task automatic test_random_pixels();
        exp_t e;
        mode = 2;
        for (int i = 0; i < 256; i++) lut[i] = 12'($urandom);
        apply_reset(int'($urandom_range(1, 1500)), int'($urandom_range(1, 8)));
        for (int i = 0; i < FRAME + 4; i++) begin
            cycle();
            e = model(cyc);
            checks++;
            if ({pixel_req, x_pos, y_pos, vga_hs, vga_vs, frame_start, vga_b, vga_g, vga_r} !== e)
                $display("[TB] FAIL random_frame: cycle %0d got req=%b x=%0d y=%0d hs=%b vs=%b fs=%b rgb=%h expected %b %0d %0d %b %b %b %h",
                         cyc, pixel_req, x_pos, y_pos, vga_hs, vga_vs, frame_start, {vga_b, vga_g, vga_r},
                         e.req, e.x, e.y, e.hs, e.vs, e.fs, e.rgb);
            else passes++;
        end
    endtask

    task automatic test_frame_wrap();
        mode = 0;
        apply_reset(int'($urandom_range(1, 1500)), 2);
        while (cyc < FRAME + 4) begin
            cycle();
            if (cyc == FRAME - 1) begin
                checks++;
                if ({pixel_req, x_pos, y_pos} !== {1'b0, 10'd0, 10'd0})
                    $display("[TB] FAIL wrap_last: got req=%b x=%0d y=%0d expected 0 0 0", pixel_req, x_pos, y_pos);
                else passes++;
            end
            if (cyc == FRAME) begin
                checks++;
                if ({pixel_req, x_pos, y_pos} !== {1'b1, 10'd0, 10'd0})
                    $display("[TB] FAIL wrap_first: got req=%b x=%0d y=%0d expected 1 0 0", pixel_req, x_pos, y_pos);
                else passes++;
            end
            if (cyc == FRAME + 1) begin
                checks++;
                if ({pixel_req, x_pos, y_pos} !== {1'b1, 10'd1, 10'd0})
                    $display("[TB] FAIL wrap_second: got req=%b x=%0d y=%0d expected 1 1 0", pixel_req, x_pos, y_pos);
                else passes++;
            end
            if (cyc >= FRAME + 1) begin
                checks++;
                if (frame_start !== (cyc == FRAME + 2))
                    $display("[TB] FAIL wrap_frame_start: cycle %0d got %b expected %b", cyc, frame_start, (cyc == FRAME + 2));
                else passes++;
            end
        end
    endtask

    initial begin
        vga_rst    = 1'b0;
        pixel_data = 12'h000;
        mode       = 0;
        prev_x     = 10'd0;
        prev_y     = 10'd0;
        checks     = 0;
        passes     = 0;
        cyc        = 0;
        for (int i = 0; i < 256; i++) lut[i] = 12'($urandom);
        @(negedge vga_clk);
        test_reset();
        test_hsync();
        test_vsync();
        test_alignment();
        test_blanking();
        test_random_pixels();
        test_frame_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

VGA display controller that generates 640x480@60 Hz raster timing from the 25 MHz pixel clock. It drives the pixel coordinate bus consumed by the pixel-source blocks and accepts their registered 12-bit colour word one cycle later. It emits monitor-facing hsync/vsync and 4-bit R/G/B, all delay-aligned so colour and sync reach the connector on the same edge. Sits between any pixel source (test pattern, framebuffer reader) and the board VGA pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks); line total 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); frame total 525

- vga_clk  in  1  pixel clock, 25 MHz; all logic on rising edge
- vga_rst  in  1  synchronous, active-low reset
- pixel_data  in  12  colour from pixel source, registered there (1-cycle latency); [11:8]=B, [7:4]=G, [3:0]=R
- x_pos  out  10  requested column, 0..639; 0 outside active region
- y_pos  out  10  requested row, 0..479; 0 outside active region
- pixel_req  out  1  high when x_pos/y_pos address a visible pixel
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_r, vga_g, vga_b  out  4 each  colour to DAC; 0 during blanking
- frame_start  out  1  one-cycle pulse marking pixel (0,0) at output

## Operation
- Stage 0: h_cnt 0..799 increments every clock, wraps to 0; v_cnt 0..524 increments when h_cnt wraps, wraps to 0 after 524 (simultaneous wrap of both at h=799,v=524 → both 0).
- de0 = (h_cnt < 640) && (v_cnt < 480). x_pos/y_pos/pixel_req driven combinationally from counters and de0; x_pos=y_pos=0 when de0 low.
- hs0 = low for h_cnt in [656, 751]; vs0 = low for v_cnt in [490, 491] (whole lines, changes at h_cnt=0).
- Stage 1: register de0, hs0, vs0, fs0 (fs0 = h_cnt==0 && v_cnt==0); pixel source returns pixel_data for stage-0 address this cycle.
- Stage 2: register outputs: vga_hs/vga_vs/frame_start from stage 1; vga_b/g/r = de1 ? pixel_data fields : 0.
- pixel_data ignored when de1 low; no back-pressure, controller never stalls.
- Reset (vga_rst low at posedge, any point in frame): h_cnt=v_cnt=0, all pipeline registers cleared, vga_hs=vga_vs=1, vga_r/g/b=0, frame_start=0; pixel_req, x_pos, y_pos forced 0 while vga_rst low. Frame restarts at (0,0) on first clock after release.

## Timing
- Address-to-pin latency: 2 clocks (stage 0 address → pixel_data valid in stage 1 → pin in stage 2). Sync signals delayed identically.
- hsync period 800 clocks, low 96; vsync period 420 000 clocks, low 1 600.
- First clock after reset release: x_pos=0, y_pos=0, pixel_req=1; frame_start high 2 clocks later, with vga_r/g/b showing pixel (0,0).
- Blanking colour is 0 on every blanked cycle, regardless of pixel_data.

## Structure
- Package vga_pkg: 640x480 timing constants, derived H_TOTAL/V_TOTAL, sync start/end values, colour field indices (B/G/R slices of 12-bit word), sync polarity constant.
- One sub-module natural: vga_scan_counter (h_cnt/v_cnt, wrap logic, de0/hs0/vs0/fs0 generation); top instance adds the two-stage alignment pipeline.

## Test plan
- Reset: hold vga_rst low 5 clocks mid-line → vga_hs=vga_vs=1, rgb=0, pixel_req=0; after release x_pos=0,y_pos=0, frame_start pulses exactly at clock 2.
- Horizontal timing: measure vga_hs → falling edges 800 clocks apart, low 96 clocks; first falling edge 658 clocks after release.
- Vertical timing: run 2 frames → vga_vs low for 1 600 clocks, period 420 000; frame_start once per 420 000 clocks.
- Alignment: model source registering pixel_data = {4'h0, y_pos[3:0], x_pos[3:0]} → at pin column 5, row 3: vga_r=5, vga_g=3, vga_b=0.
- Blanking: source drives 12'hfff constantly → rgb=0 for cycles where column ≥640 or row ≥480, rgb=F/F/F otherwise; x_pos=y_pos=0, pixel_req=0 in blanking.
- Frame wrap: observe h=799,v=524 → next clock x_pos=0,y_pos=0,pixel_req=1, no extra line inserted.
